// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: holds the fetch PC, addresses the instruction ROM,
// and buffers fetched words in a 2-entry queue toward decode.
module imem_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              out_ready,
    output logic              fetch_err
);

    localparam logic [31:0] SPAN_BYTES = 32'd4 << ADDR_W;

    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] q0_pc_q, q0_pc_d, q0_instr_q, q0_instr_d;
    logic [31:0] q1_pc_q, q1_pc_d, q1_instr_q, q1_instr_d;

    logic [31:0] off;
    logic        fault;
    logic        pop;
    logic        push;
    logic [1:0]  slot;

    assign off       = fpc_q - PC_RESET;
    assign imem_addr = off[ADDR_W+1:2];
    assign fault     = (fpc_q[1:0] != 2'b00) || (off >= SPAN_BYTES);
    assign pop       = valid_q & out_ready;
    assign push      = !redirect_valid && !err_q && !fault && ((count_q != 2'd2) || pop);
    // Tail position the incoming word lands in, after any same-cycle pop.
    assign slot      = count_q - {1'b0, pop};

    always_comb begin
        fpc_d      = fpc_q;
        count_d    = count_q;
        err_d      = err_q;
        q0_pc_d    = q0_pc_q;
        q0_instr_d = q0_instr_q;
        q1_pc_d    = q1_pc_q;
        q1_instr_d = q1_instr_q;

        if (redirect_valid) begin
            count_d = 2'd0;
            fpc_d   = redirect_pc;
            err_d   = 1'b0;
        end else begin
            if (fault) begin
                err_d = 1'b1;
            end
            if (pop && (count_q == 2'd2)) begin
                q0_pc_d    = q1_pc_q;
                q0_instr_d = q1_instr_q;
            end
            if (push) begin
                fpc_d = fpc_q + 32'd4;
                if (slot == 2'd0) begin
                    q0_pc_d    = fpc_q;
                    q0_instr_d = imem_instr;
                end else begin
                    q1_pc_d    = fpc_q;
                    q1_instr_d = imem_instr;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= PC_RESET;
            count_q    <= 2'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            q0_pc_q    <= '0;
            q0_instr_q <= '0;
            q1_pc_q    <= '0;
            q1_instr_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            q0_pc_q    <= q0_pc_d;
            q0_instr_q <= q0_instr_d;
            q1_pc_q    <= q1_pc_d;
            q1_instr_q <= q1_instr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = q0_instr_q;
    assign out_pc    = q0_pc_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural ROM where word k = A000_0000 + k.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_instr = 32'hA000_0000 + {21'd0, imem_addr};

    imem_fetch_ctrl #(
        .PC_RESET(32'h0040_0000),
        .ADDR_W  (11)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .fetch_err     (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, ins);
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset values
        #7;
        head("rst", 1'b0, 32'h0, 32'h0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_addr", {21'd0, imem_addr}, 32'd0);

        // Streaming with out_ready=1
        #5;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        head("s0", 1'b1, 32'h0040_0000, 32'hA000_0000);
        step();
        head("s1", 1'b1, 32'h0040_0004, 32'hA000_0001);
        step();
        head("s2", 1'b1, 32'h0040_0008, 32'hA000_0002);
        step();
        head("s3", 1'b1, 32'h0040_000C, 32'hA000_0003);

        // Backpressure from reset
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        head("bp1", 1'b1, 32'h0040_0000, 32'hA000_0000);
        check("bp1_addr", {21'd0, imem_addr}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            head("bp_hold", 1'b1, 32'h0040_0000, 32'hA000_0000);
            check("bp_hold_addr", {21'd0, imem_addr}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        head("bp_d1", 1'b1, 32'h0040_0004, 32'hA000_0001);
        step();
        head("bp_d2", 1'b1, 32'h0040_0008, 32'hA000_0002);
        step();
        head("bp_d3", 1'b1, 32'h0040_000C, 32'hA000_0003);

        // Redirect flushes queued entries
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", {31'd0, out_valid}, 32'd0);
        check("rd_addr", {21'd0, imem_addr}, 32'd64);
        step();
        head("rd_h0", 1'b1, 32'h0040_0100, 32'hA000_0040);
        step();
        head("rd_h1", 1'b1, 32'h0040_0104, 32'hA000_0041);

        // Last word, then out-of-range fault
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_1FFC;
        step();
        redirect_valid = 1'b0;
        check("top_valid", {31'd0, out_valid}, 32'd0);
        check("top_addr", {21'd0, imem_addr}, 32'd2047);
        step();
        head("top_h", 1'b1, 32'h0040_1FFC, 32'hA000_07FF);
        check("top_err0", {31'd0, fetch_err}, 32'd0);
        step();
        check("oor_err", {31'd0, fetch_err}, 32'd1);
        head("oor_drain", 1'b0, 32'h0040_1FFC, 32'hA000_07FF);
        check("oor_addr", {21'd0, imem_addr}, 32'd0);
        step();
        check("oor_err_sticky", {31'd0, fetch_err}, 32'd1);
        check("oor_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0000;
        step();
        redirect_valid = 1'b0;
        check("rec_err", {31'd0, fetch_err}, 32'd0);
        check("rec_valid", {31'd0, out_valid}, 32'd0);
        step();
        head("rec_h", 1'b1, 32'h0040_0000, 32'hA000_0000);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0006;
        step();
        redirect_valid = 1'b0;
        check("mis_err0", {31'd0, fetch_err}, 32'd0);
        step();
        check("mis_err1", {31'd0, fetch_err}, 32'd1);
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("mis_valid2", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with a full queue
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0000;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check("full_valid", {31'd0, out_valid}, 32'd1);
        check("full_addr", {21'd0, imem_addr}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        head("arst", 1'b0, 32'h0, 32'h0);
        check("arst_err", {31'd0, fetch_err}, 32'd0);
        check("arst_addr", {21'd0, imem_addr}, 32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        head("rs0", 1'b1, 32'h0040_0000, 32'hA000_0000);
        step();
        head("rs1", 1'b1, 32'h0040_0004, 32'hA000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the CPU31 instruction memory. The memory is a 2048x32 asynchronous-read ROM with an 11-bit word address.
- Holds the fetch PC and translates it to the memory word address.
- Buffers fetched words in a 2-entry queue with valid/ready handshake to the decode stage.
- Handles PC redirects from branch/jump resolution and flags fetches outside the memory range.

Parameters:
- PC_RESET, 32'h0040_0000, fetch PC after reset; maps to word address 0.
- ADDR_W, 11, memory word-address width; memory spans 2^ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_W  word address to instruction memory.
- imem_instr  input  32  memory read data, combinational from imem_addr in the same cycle.
- redirect_valid  input  1  one-cycle pulse: load a new fetch PC.
- redirect_pc  input  32  target PC, sampled when redirect_valid=1.
- out_valid  output  1  queue head is valid.
- out_instr  output  32  instruction at queue head.
- out_pc  output  32  byte PC of out_instr.
- out_ready  input  1  consumer accepts the head this cycle.
- fetch_err  output  1  sticky fetch fault (misaligned or out-of-range PC).

Behaviour:
- Reset (async, while rst_n=0): fpc=PC_RESET, queue count=0, out_valid=0, out_instr=0, out_pc=0, fetch_err=0.
- Address translation: off = fpc - PC_RESET (32-bit); imem_addr = off[ADDR_W+1:2] (combinational).
- Fault condition: fpc[1:0]!=0, or off >= 4*2^ADDR_W (unsigned).
- pop = out_valid & out_ready.
- push = !redirect_valid & !fetch_err & !fault & (count<2 | pop).
- Push: append {fpc, imem_instr} at the queue tail, then fpc <= fpc+4. The increment wraps mod 2^32; the range check catches overrun first.
- Simultaneous push and pop with count=2: count stays 2; head advances and the new word enters the tail.
- Pop with no push: count decrements.
- Fault with no redirect: fetch_err <= 1 at that edge; no push; fpc holds. Queued entries still drain normally.
- Redirect (highest priority):
  - count <= 0 (flush); any same-cycle pop is discarded with the flush.
  - fpc <= redirect_pc; fetch_err <= 0; no push that edge.
- out_valid = (count!=0), registered state. out_instr and out_pc come from queue-head registers and hold while out_valid=1 and out_ready=0.
- When count=0, out_instr and out_pc hold their last values.
- Latency:
  - After reset release, the first edge pushes PC_RESET; out_valid=1 after that edge.
  - After a redirect edge, out_valid=0 for one cycle; redirect_pc appears at the head after the next edge.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- imem_addr is stable whenever fpc is stable, including stalls and faults.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk.

Test Plan:
- Reset, then out_ready=1 for 4 cycles with ROM word k = 32'hA000_0000+k -> out_pc sequence 0x00400000, 0x00400004, 0x00400008; out_instr A0000000, A0000001, A0000002; out_valid=1 from the first edge after reset.
- Hold out_ready=0 for 5 cycles -> count saturates at 2; out_pc held at 0x00400000; imem_addr held at 2. Raise out_ready -> entries 0 and 1 then 2 delivered with no gap or duplicate.
- Steady stream, redirect_valid=1 with redirect_pc=0x00400100 -> next cycle out_valid=0; following cycle out_pc=0x00400100, out_instr=word 64; no stale entries delivered.
- Redirect to 0x00401FFC (word 2047), out_ready=1 -> word 2047 delivered; then fetch_err=1; fpc holds at 0x00402000; out_valid drops after the drain. Redirect to 0x00400000 -> fetch_err=0 and fetch resumes.
- Redirect to 0x00400006 -> fetch_err=1 at the next edge; nothing pushed.
- Assert rst_n=0 asynchronously mid-stream with count=2 -> out_valid=0, fetch_err=0, imem_addr=0 before the next clk edge. Release -> sequence restarts at 0x00400000.
